// File: rtl/mem_readout_axis_pkg.sv
// Shared definitions for the capture-buffer readout: FSM encoding, output FIFO depth, log2 helper.
package mem_readout_axis_pkg;

    typedef enum logic [1:0] {
        MRD_IDLE  = 2'd0,
        MRD_READ  = 2'd1,
        MRD_DRAIN = 2'd2
    } mrd_state_t;

    localparam int MRD_FIFO_DEPTH = 4;

    // Number of bits needed to represent value (at least 1).
    function automatic int mrd_log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/axis_fifo_fwft.sv
// Small synchronous first-word-fall-through FIFO; head entry is visible while not empty.
// Push is unchecked: the producer must never push when full.
module axis_fifo_fwft
    import mem_readout_axis_pkg::*;
#(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = mrd_log2(DEPTH - 1),
    localparam int CNT_W = mrd_log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    // Gate the head so stale storage never shows up on the outputs.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_readout_axis.sv
// Sweeps a circular capture buffer from oldest to newest sample and streams it as one AXI-stream frame.
// Issue is credit-limited so the 1-cycle read pipeline plus FIFO never holds more than 4 beats.
module mem_readout_axis
    import mem_readout_axis_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int MEMORY_DEPTH = 32,
    localparam int ADDR_WIDTH   = mrd_log2(MEMORY_DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    localparam int FC_W = mrd_log2(MRD_FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

    mrd_state_t            state;
    mrd_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] issue_cnt;
    logic                  v1;
    logic                  v2;
    logic                  last1;
    logic                  last2;
    logic [FC_W-1:0]       fifo_count;
    logic [FC_W:0]         committed;
    logic                  fifo_empty;
    logic                  issue;
    logic                  pop;
    logic [DATA_WIDTH:0]   head_data;

    // Beats in flight: still in the read pipeline or already queued.
    assign committed = (FC_W+1)'(fifo_count) + (FC_W+1)'(v1) + (FC_W+1)'(v2);
    assign pop       = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = (state != MRD_IDLE);
        case (state)
            MRD_IDLE: begin
                if (start) state_nxt = MRD_READ;
            end
            MRD_READ: begin
                issue = (committed < (FC_W+1)'(MRD_FIFO_DEPTH));
                if (issue && issue_cnt == LAST_ADDR) state_nxt = MRD_DRAIN;
            end
            MRD_DRAIN: begin
                if (!v1 && !v2 && pop && m_axis_tlast) state_nxt = MRD_IDLE;
            end
            default: state_nxt = MRD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MRD_IDLE;
            issue_cnt <= '0;
            addr      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            last1     <= 1'b0;
            last2     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == MRD_IDLE && start) issue_cnt <= '0;
            if (issue) begin
                addr      <= issue_cnt;
                issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
                v1        <= 1'b1;
                last1     <= (issue_cnt == LAST_ADDR);
            end else begin
                v1    <= 1'b0;
                last1 <= 1'b0;
            end
            v2    <= v1;
            last2 <= last1;
        end
    end

    axis_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (MRD_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (v2),
        .push_data ({last2, din}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = head_data[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head_data[DATA_WIDTH];

endmodule

// File: tb/tb_mem_readout_axis.sv
// Scoreboarded bench for mem_readout_axis with an 8-entry capture buffer model.
module tb_mem_readout_axis;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic [2:0]    addr;
    logic [DW-1:0] din;
    logic          tvalid;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tlast;

    logic [DW-1:0] buf_mem [DEPTH];
    logic [DW:0]   exp_q [$];
    int            checks   = 0;
    int            failures = 0;
    int            beats    = 0;
    int            lasts    = 0;
    logic          hold_vld = 1'b0;
    logic [DW:0]   hold_word;

    always #5 clk = ~clk;

    // Capture buffer model: registered read, one cycle latency.
    always @(posedge clk) din <= buf_mem[addr];

    mem_readout_axis #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .addr          (addr),
        .din           (din),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("stall_tvalid", 64'(tvalid), 64'd1);
                check("stall_word", 64'({tlast, tdata}), 64'(hold_word));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=none", {tlast, tdata});
                end else begin
                    check("beat", 64'({tlast, tdata}), 64'(exp_q.pop_front()));
                end
                beats++;
                if (tlast) lasts++;
                hold_vld = 1'b0;
            end else if (tvalid) begin
                hold_vld  = 1'b1;
                hold_word = {tlast, tdata};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_pattern(input bit sparse);
        for (int i = 0; i < DEPTH; i++)
            buf_mem[i] = (sparse && i < 6) ? '0 : DW'(32'h10 + i);
    endtask

    task automatic expect_beats(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == DEPTH - 1), buf_mem[i]});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic frame_end(input string name);
        wait_idle({name, "_idle"});
        repeat (3) tick();
        check({name, "_beats"}, 64'(beats), 64'd8);
        check({name, "_lasts"}, 64'(lasts), 64'd1);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_still_idle"}, 64'(busy), 64'd0);
        beats = 0;
        lasts = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_cnt;
        int n;

        load_pattern(1'b0);
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        rst = 1'b0;
        tick();

        // 1: free-running frame, latency and throughput
        tready = 1'b1;
        expect_beats(DEPTH);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("t1_addr", 64'(addr), 64'(i));
            if (i == 1) check("t1_tvalid_k2", 64'(tvalid), 64'd0);
            if (i == 2) check("t1_tvalid_k3", 64'(tvalid), 64'd1);
        end
        tick();
        tick();
        check("t1_busy_k10", 64'(busy), 64'd1);
        tick();
        check("t1_busy_k11", 64'(busy), 64'd0);
        frame_end("t1");

        // 2: tready toggling every cycle
        expect_beats(DEPTH);
        max_cnt = 0;
        n = 0;
        pulse_start();
        while (busy && n < 200) begin
            tready = ~tready;
            tick();
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            n++;
        end
        check("t2_fifo_le4", 64'(max_cnt <= 4), 64'd1);
        tready = 1'b1;
        frame_end("t2");

        // 3: long stall caps issue at four addresses
        tready = 1'b0;
        expect_beats(DEPTH);
        pulse_start();
        repeat (10) tick();
        check("t3_addr_c10", 64'(addr), 64'd3);
        repeat (10) tick();
        check("t3_addr_c20", 64'(addr), 64'd3);
        check("t3_tvalid", 64'(tvalid), 64'd1);
        check("t3_tdata", 64'(tdata), 64'h10);
        tready = 1'b1;
        frame_end("t3");

        // 4: extra start pulses during an active frame
        expect_beats(DEPTH);
        pulse_start();
        for (int c = 1; c <= 14; c++) begin
            start = (c == 2 || c == 5);
            tick();
        end
        start = 1'b0;
        frame_end("t4");

        // 5: reset while 0x13 is pending
        tready = 1'b1;
        expect_beats(3);
        pulse_start();
        repeat (6) tick();
        check("t5_pending_tvalid", 64'(tvalid), 64'd1);
        check("t5_pending_tdata", 64'(tdata), 64'h13);
        tready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_tvalid", 64'(tvalid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_addr", 64'(addr), 64'd0);
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
        beats = 0;
        lasts = 0;
        repeat (2) tick();
        tready = 1'b1;
        expect_beats(DEPTH);
        pulse_start();
        frame_end("t5_refill");

        // 6: zero-filled entries pass through
        load_pattern(1'b1);
        expect_beats(DEPTH);
        pulse_start();
        frame_end("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_readout_axis.md
# mem_readout_axis

Streams the full contents of a circular capture buffer out as one AXI-stream frame. On a start pulse it sweeps the buffer's relative read address from 0 (oldest sample) to MEMORY_DEPTH-1 (newest sample). It absorbs the buffer's 1-cycle registered read latency and honours downstream backpressure through a small credit-controlled output FIFO. It sits directly downstream of the capture buffer: it drives that buffer's `addr` input and consumes its `dout` output.

## Interface
- `DATA_WIDTH`, 32: sample width in bits; must match the capture buffer.
- `MEMORY_DEPTH`, 32: number of buffer entries, which is also the frame length in beats. Minimum 2.
- `ADDR_WIDTH` (derived): log2(MEMORY_DEPTH-1).
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request to read out one frame; ignored unless the block is idle.
- `busy`  out  1  high from the start acceptance until the last beat is accepted downstream. Upstream capture must hold its write valid low while `busy` is high.
- `addr`  out  ADDR_WIDTH  relative read address to the buffer; registered.
- `din`  in  DATA_WIDTH  buffer read data; valid one cycle after `addr` changes (READ_LATENCY 1).
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  DATA_WIDTH  output sample.
- `m_axis_tlast`  out  1  high on the beat read from address MEMORY_DEPTH-1.

## Operation
- **States:**
  - IDLE: on `start`, go to READ and set the issue counter to 0.
  - READ: issue one address per cycle while credit allows. After issuing MEMORY_DEPTH-1, go to DRAIN.
  - DRAIN: wait until the pipeline and FIFO are empty and the last beat has handshaked, then go to IDLE.
- **Issue:**
  - An address is issued at an edge where the state is READ and `fifo_count + v1 + v2 < 4`. All terms are registered.
  - On issue: `addr` <= issue counter, `v1` <= 1, counter increments.
  - Otherwise `v1` <= 0 and `addr` holds its value.
  - `v2` <= `v1` on every edge.
  - When `v2` is set, `din` and a last flag are written into the FIFO. The last flag is carried down the v1/v2 pipeline; it is set for address MEMORY_DEPTH-1.
- **Output FIFO:** 4 entries, first-word fall-through.
  - `m_axis_tvalid` = FIFO not empty; head entry drives `tdata` and `tlast`.
  - Pop when `tvalid & tready`.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees the FIFO never overflows, so no full check is needed on push.
- **Data and arithmetic:**
  - Data passes through unmodified; zero-filled entries from the buffer are forwarded as-is.
  - The address counter is ADDR_WIDTH wide. It never wraps within a frame; it is reset to 0 on start.
- **Boundary behaviour:**
  - `start` while not in IDLE: ignored, no queueing.
  - `start` in the same cycle that DRAIN exits: ignored; IDLE must be observed first.
  - `tready` held low: issue stalls once 4 beats are committed. No beats are lost or duplicated.
  - `rst` mid-frame: the frame is aborted. No `tlast` is emitted and the remaining FIFO contents are discarded.
- **`busy`:** equals (state != IDLE).

## Timing
- **Reset values:** state IDLE; `busy` 0; `addr` 0; `m_axis_tvalid` 0; `m_axis_tlast` 0; `m_axis_tdata` 0; `v1`/`v2`/FIFO count 0.
- **Start latency:**
  - `start` sampled at edge k.
  - `addr`=0 from edge k+1.
  - `din` valid after edge k+2.
  - FIFO write at edge k+3; first `tvalid` high after edge k+3.
- **Throughput:** 1 beat/cycle sustained with `tready` held high. A frame of D beats completes D+3 cycles after start.
- **`busy` deassertion:** `busy` falls the edge after the last-beat handshake.
- **AXI-stream rule:** once `tvalid` is high, `tdata`/`tlast`/`tvalid` stay stable until the handshake.

## Structure
- **Shared package:**
  - state encoding `MRD_IDLE`/`MRD_READ`/`MRD_DRAIN` (2 bits);
  - `MRD_FIFO_DEPTH` = 4;
  - log2 function (reuse the existing include).
- **Sub-module `axis_fifo_fwft`:** a generic small synchronous first-word-fall-through FIFO.
  - parameters: WIDTH (DATA_WIDTH+1), DEPTH;
  - outputs: count, empty.
- The top level holds the FSM, the issue counter and the v1/v2 pipeline.

## Test plan
1. MEMORY_DEPTH=8, buffer model holds 0x10..0x17, `tready`=1, start pulse → `addr` 0..7 on consecutive cycles; tdata 0x10..0x17 on consecutive cycles; `tlast` only with 0x17; first `tvalid` 3 edges after start; `busy` low after the last beat.
2. Same frame, `tready` toggled 1/0 each cycle → all 8 beats in order, no duplicates; `fifo_count` never exceeds 4; `tdata` stable while stalled.
3. `tready`=0 for 20 cycles after start → exactly 4 addresses issued (0..3); `tvalid` held high with 0x10; releasing `tready` delivers all 8 beats.
4. Second `start` pulses at cycles 2 and 5 of an active frame → ignored; exactly 8 beats and one `tlast` produced.
5. `rst` asserted while the beat with 0x13 is pending → next cycle `tvalid`=0, `busy`=0, `addr`=0; a fresh start then yields the full 0x10..0x17 frame.
6. Buffer returns 0 for unwritten entries (only 0x16, 0x17 valid) → frame 0,0,0,0,0,0,0x16,0x17 with `tlast` on 0x17.
